alu_mc: RTL
===========

// Module: alu_mc
// PURPOSE
//  Parametrised multi-cycle integer ALU: next-generation execute unit for the RV32/64 core.
//  Covers all base ALU ops (1-cycle) and an iterative MUL/DIV unit (XLEN cycles), behind valid/ready handshakes.
//  Sits between decode/issue and writeback; a flush input lets the pipeline squash an op in flight.
// PARAMETERS
//  XLEN     32   operand/result width; power of two, 8..64
//  SHAMT_W  $clog2(XLEN)   derived shift-amount width (localparam, not overridable)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  flush      in   1      synchronous squash: abort op in flight, drop held result
//  in_valid   in   1      operands/op valid
//  in_ready   out  1      unit can accept an op this cycle
//  a          in   XLEN   operand A
//  b          in   XLEN   operand B
//  op         in   5      alu_op_e opcode
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  result     out  XLEN   result
//  zero       out  1      result == 0
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, result=0, zero=1.
//  Ops: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9 (shift by b[SHAMT_W-1:0]);
//   MUL 10, MULH 11, MULHU 12, MULHSU 13, DIV 14, DIVU 15, REM 16, REMU 17; codes 18..31 -> result 0, latency 1.
//  FSM: IDLE -(accept, base op)-> DONE; IDLE -(accept, mul/div)-> BUSY; BUSY -(count==XLEN-1)-> DONE;
//   DONE -(out_ready)-> IDLE, or directly re-accepts a new op the same cycle.
//  Accept = in_valid & in_ready; in_ready = (state==IDLE) | (state==DONE & out_ready); not while BUSY.
//  Latency: base op out_valid the cycle after accept; mul/div out_valid XLEN+1 cycles after accept.
//  out_valid=1 only in DONE; result/zero stable while out_valid & !out_ready.
//  MUL: radix-2 shift-add over 2*XLEN product; MUL low half, MULH/MULHU/MULHSU high half with
//   signed*signed / unsigned*unsigned / signed(a)*unsigned(b) operand handling (sign-fix on entry/exit).
//  DIV: restoring, magnitudes then sign-fix; quotient sign = sa^sb, remainder sign = sign of a.
//  Div by zero: DIV/DIVU -> all ones, REM/REMU -> a. Overflow (DIV, a=MIN, b=-1): quotient MIN, REM 0.
//   Both corner cases still take the full XLEN+1 latency (fixed timing).
//  flush: highest priority after reset; next state IDLE, out_valid=0, in-flight op discarded,
//   in_valid that same cycle is NOT accepted.
//  Reset mid-op: asynchronous return to reset values; partial product/quotient discarded.
//  Wrap: ADD/SUB modulo 2^XLEN, no overflow flag.
// CONFIGURATION
//  ALU_MDU_EN defined: ops 10..17 implemented as above.
//  Not defined: MUL/DIV datapath and BUSY state removed; ops 10..17 behave as unknown codes
//   (result 0, zero=1, latency 1).
// STRUCTURE
//  Package alu_pkg: typedef enum logic [4:0] alu_op_e, typedef enum alu_state_e {IDLE,BUSY,DONE},
//   function is_mdu_op(alu_op_e).
//  Sub-module alu_mdu (iterative mul/div core: start, op, a, b -> done, res); alu_mc owns
//   handshake FSM and base-op combinational datapath.
// TESTING
//  Reset mid-DIVU (cycle 5 of 32) -> out_valid=0, in_ready=1, zero=1 immediately; next ADD 2+3 -> 5.
//  ADD 0xFFFFFFFF+1 -> result 0, zero=1, out_valid 1 cycle after accept; SRA 0x80000000>>4 -> 0xF8000000.
//  MULH 0xFFFFFFFF*0xFFFFFFFF -> 0; MULHU same -> 0xFFFFFFFE; MULHSU -1*2 -> 0xFFFFFFFF; latency 33.
//  DIV 7/0 -> 0xFFFFFFFF, REM 7/0 -> 7; DIV 0x80000000/-1 -> 0x80000000, REM -> 0; DIV -7/2 -> -3, REM -> -1.
//  Backpressure: out_ready=0 for 5 cycles -> result held, in_ready=0; raise out_ready with in_valid -> back-to-back accept.
//  flush at cycle 10 of MUL -> out_valid never asserts for it; following SUB 3-5 -> 0xFFFFFFFE.
//  Build without ALU_MDU_EN: MUL 3*4 -> result 0, zero=1, 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode/state types and opcode classification helpers for the alu_mc execute unit.
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_SLT    = 5'd8,
        ALU_SLTU   = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHU  = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    function automatic logic is_mdu_op(alu_op_e op);
        return (op >= ALU_MUL) && (op <= ALU_REMU);
    endfunction

    function automatic logic is_div_op(alu_op_e op);
        return (op >= ALU_DIV) && (op <= ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Issue/writeback handshake bundle between the pipeline and the alu_mc execute unit.
interface alu_mc_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      op;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_mdu.sv
// Iterative radix-2 multiplier / restoring divider: magnitudes in, sign-fix out, fixed XLEN-cycle run.
module alu_mdu import alu_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] res
);
    localparam int CNT_W = $clog2(XLEN);

    logic              busy_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q, acc_step, prod_s;
    logic [XLEN-1:0]   mag_q, a_q, ma, mb, quo, rem;
    alu_op_e           op_q;
    logic              neg_q, neg_r_q, dz_q, sa, sb;
    logic [XLEN:0]     mul_sum, div_tmp, div_diff;

    always_comb begin
        sa = a[XLEN-1] & (op == ALU_MUL || op == ALU_MULH || op == ALU_MULHSU ||
                          op == ALU_DIV || op == ALU_REM);
        sb = b[XLEN-1] & (op == ALU_MUL || op == ALU_MULH || op == ALU_DIV || op == ALU_REM);
        ma = sa ? -a : a;
        mb = sb ? -b : b;
    end

    // acc_q holds {hi, lo} of the product, or {remainder, dividend/quotient} when dividing
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? mag_q : '0)};
        div_tmp  = acc_q[2*XLEN-1:XLEN-1];
        div_diff = div_tmp - {1'b0, mag_q};
        if (is_div_op(op_q)) begin
            if (div_diff[XLEN]) acc_step = {div_tmp[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            else                acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    always_comb begin
        prod_s = neg_q ? -acc_step : acc_step;
        quo    = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem    = neg_r_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        case (op_q)
            ALU_MUL:                        res = prod_s[XLEN-1:0];
            ALU_MULH, ALU_MULHU, ALU_MULHSU: res = prod_s[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:              res = dz_q ? '1 : quo;
            ALU_REM, ALU_REMU:              res = dz_q ? a_q : rem;
            default:                        res = '0;
        endcase
    end

    assign done = busy_q && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            mag_q   <= '0;
            a_q     <= '0;
            op_q    <= ALU_ADD;
            neg_q   <= 1'b0;
            neg_r_q <= 1'b0;
            dz_q    <= 1'b0;
        end else if (flush) begin
            busy_q <= 1'b0;
        end else if (start) begin
            busy_q  <= 1'b1;
            cnt_q   <= CNT_W'(XLEN-1);
            op_q    <= op;
            a_q     <= a;
            neg_q   <= sa ^ sb;
            neg_r_q <= sa;
            dz_q    <= (b == '0);
            if (is_div_op(op)) begin
                acc_q <= {{XLEN{1'b0}}, ma};
                mag_q <= mb;
            end else begin
                acc_q <= {{XLEN{1'b0}}, mb};
                mag_q <= ma;
            end
        end else if (busy_q) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == '0) busy_q <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU: handshake FSM plus single-cycle base ops.
// Mul/div ops are only implemented when ALU_MDU_EN is defined; otherwise they act as unknown codes.
//
// state | meaning
// IDLE  | no result held, ready for an op
// BUSY  | alu_mdu iterating, not accepting
// DONE  | result held until out_ready; may re-accept in the same cycle
module alu_mc import alu_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    alu_mc_if.slave  bus
);
    localparam int SHAMT_W = $clog2(XLEN);

    alu_state_e         state_q, state_d;
    logic [XLEN-1:0]    result_q, result_d, base_res;
    logic [SHAMT_W-1:0] shamt;
    logic               in_ready, out_valid, accept, take_mdu;

`ifdef ALU_MDU_EN
    logic               mdu_done;
    logic [XLEN-1:0]    mdu_res;

    assign take_mdu = is_mdu_op(alu_op_e'(bus.op));

    alu_mdu #(.XLEN(XLEN)) u_mdu (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .start (accept & take_mdu),
        .op    (alu_op_e'(bus.op)),
        .a     (bus.a),
        .b     (bus.b),
        .done  (mdu_done),
        .res   (mdu_res)
    );
`else
    assign take_mdu = 1'b0;
`endif

    assign shamt  = bus.b[SHAMT_W-1:0];
    assign accept = bus.in_valid & in_ready & ~flush;

    always_comb begin
        case (bus.op)
            ALU_ADD:  base_res = bus.a + bus.b;
            ALU_SUB:  base_res = bus.a - bus.b;
            ALU_AND:  base_res = bus.a & bus.b;
            ALU_OR:   base_res = bus.a | bus.b;
            ALU_XOR:  base_res = bus.a ^ bus.b;
            ALU_SLL:  base_res = bus.a << shamt;
            ALU_SRL:  base_res = bus.a >> shamt;
            ALU_SRA:  base_res = $signed(bus.a) >>> shamt;
            ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
            default:  base_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) state_d = take_mdu ? BUSY : DONE;
`ifdef ALU_MDU_EN
                BUSY: if (mdu_done) state_d = DONE;
`endif
                DONE: begin
                    if (accept)             state_d = take_mdu ? BUSY : DONE;
                    else if (bus.out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (accept && !take_mdu) result_d = base_res;
`ifdef ALU_MDU_EN
            if (state_q == BUSY && mdu_done) result_d = mdu_res;
`endif
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
        out_valid = (state_q == DONE);
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.result    = result_q;
    assign bus.zero      = (result_q == '0);
endmodule
